// File: rtl/touch_pkg.sv
// Shared types and constants for the touch-panel ADC sequencer.
// Sub-frame positions describe one 24-clock ADS7843-class conversion.
package touch_pkg;

  localparam int COORD_W    = 12;
  localparam int FRAME_BITS = 24;
  localparam int DATA_FIRST = 9;
  localparam int DATA_LAST  = 20;

  localparam logic [7:0] CMD_X_DEF = 8'h92;
  localparam logic [7:0] CMD_Y_DEF = 8'hD2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_PUBLISH = 2'd2,
    ST_GAP     = 2'd3
  } touch_state_e;

endpackage

// File: rtl/touch_spi_frame.sv
// Serial timing engine for one 48-bit X+Y frame: DCLK, DIN, bit index and
// the DOUT capture strobe. Counters sit at zero whenever i_en is low.
module touch_spi_frame
  import touch_pkg::*;
#(
  parameter int         CLK_DIV = 25,
  parameter logic [7:0] CMD_X   = CMD_X_DEF,
  parameter logic [7:0] CMD_Y   = CMD_Y_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       i_en,
  output logic       o_dclk,
  output logic       o_din,
  output logic [5:0] o_bit,
  output logic       o_sample,
  output logic       o_done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic [5:0]       r_bit;

  logic       w_div_end;
  logic       w_bit_end;
  logic       w_sub_y;
  logic [4:0] w_k;
  logic [7:0] w_cmd;
  logic       w_in_data;

  assign w_div_end = (r_div == DIV_LAST);
  assign w_bit_end = r_phase & w_div_end;
  assign o_done    = i_en & w_bit_end & (r_bit == 6'd47);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else if (!i_en || o_done) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else begin
      r_div <= w_div_end ? '0 : r_div + 1'b1;
      if (w_div_end) r_phase <= ~r_phase;
      if (w_bit_end) r_bit <= r_bit + 1'b1;
    end
  end

  // Position inside the current 24-bit sub-frame selects command bit or data slot
  assign w_sub_y   = (r_bit >= 6'(FRAME_BITS));
  assign w_k       = w_sub_y ? 5'(r_bit - 6'(FRAME_BITS)) : r_bit[4:0];
  assign w_cmd     = w_sub_y ? CMD_Y : CMD_X;
  assign w_in_data = (w_k >= 5'(DATA_FIRST)) && (w_k <= 5'(DATA_LAST));

  assign o_dclk   = r_phase;
  assign o_din    = i_en & (w_k < 5'd8) & w_cmd[3'(5'd7 - w_k)];
  assign o_bit    = r_bit;
  assign o_sample = i_en & r_phase & (r_div == '0) & w_in_data;

endmodule

// File: rtl/touch_adc_sequencer.sv
// Pen-down driven X/Y conversion sequencer for a 4-wire touch ADC; publishes
// a consistent coordinate pair with a one-cycle strobe at a fixed interval.
module touch_adc_sequencer
  import touch_pkg::*;
#(
  parameter int          CLK_DIV    = 25,
  parameter logic [23:0] SAMPLE_GAP = 24'd500000,
  parameter logic [7:0]  CMD_X      = CMD_X_DEF,
  parameter logic [7:0]  CMD_Y      = CMD_Y_DEF
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iPENIRQ_n,
  input  logic               iADC_DOUT,
  output logic               oADC_DCLK,
  output logic               oADC_DIN,
  output logic               oADC_CS_n,
  output logic [COORD_W-1:0] oX_COORD,
  output logic [COORD_W-1:0] oY_COORD,
  output logic               oNEW_COORD,
  output logic               oTOUCH_IRQ
);

  touch_state_e r_state;
  touch_state_e w_next;

  logic               r_sync1;
  logic               r_sync2;
  logic [23:0]        r_gap;
  logic [COORD_W-1:0] r_shadow_x;
  logic [COORD_W-1:0] r_shadow_y;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_new;

  logic       w_irq;
  logic       w_conv;
  logic       w_cs_n;
  logic       w_publish;
  logic       w_gap_end;
  logic       w_dclk;
  logic       w_din;
  logic [5:0] w_bit;
  logic       w_sample;
  logic       w_done;

  // Sync flops reset to "pen up" so the IRQ output starts deasserted
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= iPENIRQ_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = ~r_sync2;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_irq) w_next = ST_CONV;
      ST_CONV:    if (w_done) w_next = ST_PUBLISH;
      ST_PUBLISH: w_next = ST_GAP;
      ST_GAP:     if (w_gap_end) w_next = w_irq ? ST_CONV : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_conv    = (r_state == ST_CONV);
    w_cs_n    = ~w_conv;
    w_publish = (r_state == ST_PUBLISH) & w_irq;
  end

  touch_spi_frame #(
    .CLK_DIV (CLK_DIV),
    .CMD_X   (CMD_X),
    .CMD_Y   (CMD_Y)
  ) u_frame (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .i_en     (w_conv),
    .o_dclk   (w_dclk),
    .o_din    (w_din),
    .o_bit    (w_bit),
    .o_sample (w_sample),
    .o_done   (w_done)
  );

  // Gap counter idles at zero, so GAP always starts counting from a clean value
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)                r_gap <= '0;
    else if (r_state != ST_GAP) r_gap <= '0;
    else                        r_gap <= r_gap + 1'b1;
  end

  assign w_gap_end = (r_gap == SAMPLE_GAP);

  // Shadows are fully rewritten by every completed frame and never seen directly
  always_ff @(posedge iCLK) begin
    if (w_sample) begin
      if (w_bit >= 6'(FRAME_BITS)) r_shadow_y <= {r_shadow_y[COORD_W-2:0], iADC_DOUT};
      else                         r_shadow_x <= {r_shadow_x[COORD_W-2:0], iADC_DOUT};
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_new <= 1'b0;
    end else begin
      r_new <= w_publish;
      if (w_publish) begin
        r_x <= r_shadow_x;
        r_y <= r_shadow_y;
      end
    end
  end

  assign oADC_DCLK  = w_dclk;
  assign oADC_DIN   = w_din;
  assign oADC_CS_n  = w_cs_n;
  assign oX_COORD   = r_x;
  assign oY_COORD   = r_y;
  assign oNEW_COORD = r_new;
  assign oTOUCH_IRQ = w_irq;

endmodule

// File: tb/tb_touch_adc_sequencer.sv
// Directed/randomized bench for touch_adc_sequencer with a behavioural ADC
// model that serves per-frame X/Y words and records the command bytes.
module tb_touch_adc_sequencer;

  localparam int CLK_DIV   = 25;
  localparam int GAP       = 1000;
  localparam int FRAME_CYC = 48 * 2 * CLK_DIV;
  localparam int LATENCY   = 2 + 1 + FRAME_CYC + 1;
  localparam int PERIOD    = FRAME_CYC + 1 + GAP + 1;

  logic        iCLK;
  logic        iRST_n;
  logic        iPENIRQ_n;
  logic        iADC_DOUT = 1'b0;
  logic        oADC_DCLK;
  logic        oADC_DIN;
  logic        oADC_CS_n;
  logic [11:0] oX_COORD;
  logic [11:0] oY_COORD;
  logic        oNEW_COORD;
  logic        oTOUCH_IRQ;

  touch_adc_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_GAP (24'(GAP))
  ) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iPENIRQ_n  (iPENIRQ_n),
    .iADC_DOUT  (iADC_DOUT),
    .oADC_DCLK  (oADC_DCLK),
    .oADC_DIN   (oADC_DIN),
    .oADC_CS_n  (oADC_CS_n),
    .oX_COORD   (oX_COORD),
    .oY_COORD   (oY_COORD),
    .oNEW_COORD (oNEW_COORD),
    .oTOUCH_IRQ (oTOUCH_IRQ)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge iCLK) cyc++;

  // ADC model state
  logic [11:0] xs [32];
  logic [11:0] ys [32];
  logic        fill_ones = 1'b0;
  int          m_frames = 0;
  int          m_rises = 0;
  int          m_falls = 0;
  int          m_last_rises = 0;
  logic [47:0] m_din = '0;
  logic [7:0]  m_cmd_x = '0;
  logic [7:0]  m_cmd_y = '0;
  logic        m_dclk_q = 1'b0;
  logic        m_cs_q = 1'b1;

  function automatic logic adc_bit(input int frame, input int idx);
    int          k;
    logic [11:0] w;
    if (idx >= 48) return 1'b0;
    k = idx % 24;
    w = (idx < 24) ? xs[frame % 32] : ys[frame % 32];
    if (k >= 9 && k <= 20) return w[20 - k];
    return fill_ones ? 1'b1 : 1'($urandom_range(1, 0));
  endfunction

  always @(negedge iCLK) begin
    if (!oADC_CS_n && oADC_DCLK && !m_dclk_q) begin
      if (m_rises < 48) m_din[47 - m_rises] = oADC_DIN;
      m_rises++;
    end
    if (!oADC_CS_n && !oADC_DCLK && m_dclk_q) m_falls++;
    if (oADC_CS_n && !m_cs_q) begin
      m_frames++;
      m_last_rises = m_rises;
      m_cmd_x = m_din[47:40];
      m_cmd_y = m_din[23:16];
    end
    if (oADC_CS_n) begin
      m_rises = 0;
      m_falls = 0;
    end
    iADC_DOUT = adc_bit(m_frames, m_falls);
    m_dclk_q  = oADC_DCLK;
    m_cs_q    = oADC_CS_n;
  end

  // Strobe / IRQ monitor
  int          s_cyc [$];
  logic [11:0] s_x [$];
  logic [11:0] s_y [$];
  int          back2back = 0;
  int          irq_hi = 0;
  logic        prev_new = 1'b0;

  always @(negedge iCLK) begin
    if (oNEW_COORD) begin
      if (prev_new) back2back++;
      s_cyc.push_back(cyc);
      s_x.push_back(oX_COORD);
      s_y.push_back(oY_COORD);
    end
    prev_new = oNEW_COORD;
    if (oTOUCH_IRQ) irq_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int i = 0;
    while (s_cyc.size() < n && i < budget) begin
      @(posedge iCLK);
      i++;
    end
    #1;
    check(tag, 32'(s_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string tag);
    int i = 0;
    while (oADC_CS_n !== lvl && i < budget) begin
      @(posedge iCLK);
      #1;
      i++;
    end
    check(tag, 32'(oADC_CS_n === lvl), 32'd1);
  endtask

  initial begin
    int          f0;
    int          n0;
    int          t0;
    int          irq0;
    int          i;
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] vals [2];

    for (int j = 0; j < 32; j++) begin
      xs[j] = 12'($urandom);
      ys[j] = 12'($urandom);
    end
    iRST_n    = 1'b0;
    iPENIRQ_n = 1'b1;
    idle(5);
    check("rst_cs_n",  32'(oADC_CS_n),  32'd1);
    check("rst_dclk",  32'(oADC_DCLK),  32'd0);
    check("rst_din",   32'(oADC_DIN),   32'd0);
    check("rst_x",     32'(oX_COORD),   32'd0);
    check("rst_y",     32'(oY_COORD),   32'd0);
    check("rst_new",   32'(oNEW_COORD), 32'd0);
    check("rst_irq",   32'(oTOUCH_IRQ), 32'd0);
    iRST_n = 1'b1;
    idle(5);

    // Single touch
    f0 = m_frames;
    xs[f0] = 12'hABC;
    ys[f0] = 12'h123;
    n0 = s_cyc.size();
    @(posedge iCLK); #1;
    iPENIRQ_n = 1'b0;
    t0 = cyc;
    wait_strobes(n0 + 1, LATENCY + 200, "t1_strobe_timeout");
    if (s_cyc.size() > n0) begin
      check("t1_latency", 32'(s_cyc[n0] - t0), 32'(LATENCY));
      check("t1_x", 32'(s_x[n0]), 32'h0ABC);
      check("t1_y", 32'(s_y[n0]), 32'h0123);
    end
    while (cyc - t0 < 3000) @(posedge iCLK);
    #1;
    iPENIRQ_n = 1'b1;
    idle(1500);
    check("t1_strobe_count", 32'(s_cyc.size() - n0), 32'd1);
    check("t1_frames", 32'(m_frames - f0), 32'd1);
    check("t1_cmd_x", 32'(m_cmd_x), 32'h92);
    check("t1_cmd_y", 32'(m_cmd_y), 32'hD2);
    check("t1_rises", 32'(m_last_rises), 32'd48);
    check("t1_idle_cs", 32'(oADC_CS_n), 32'd1);
    check("t1_irq_low", 32'(oTOUCH_IRQ), 32'd0);

    // Held pen: alternating X, strobes every PERIOD cycles
    f0 = m_frames;
    for (int j = 0; j < 4; j++) xs[f0 + j] = (j % 2 == 1) ? 12'hFFF : 12'h001;
    n0 = s_cyc.size();
    @(posedge iCLK); #1;
    iPENIRQ_n = 1'b0;
    wait_strobes(n0 + 3, 3 * PERIOD + 200, "t2_strobe_timeout");
    iPENIRQ_n = 1'b1;
    if (s_cyc.size() >= n0 + 3) begin
      check("t2_gap01", 32'(s_cyc[n0 + 1] - s_cyc[n0]), 32'(PERIOD));
      check("t2_gap12", 32'(s_cyc[n0 + 2] - s_cyc[n0 + 1]), 32'(PERIOD));
      for (int j = 0; j < 3; j++) begin
        check("t2_x", 32'(s_x[n0 + j]), 32'(xs[f0 + j]));
        check("t2_y", 32'(s_y[n0 + j]), 32'(ys[f0 + j]));
      end
    end
    px = xs[f0 + 2];
    py = ys[f0 + 2];
    idle(2000);
    check("t2_strobe_count", 32'(s_cyc.size() - n0), 32'd3);
    check("t2_idle_cs", 32'(oADC_CS_n), 32'd1);

    // Release mid-frame: frame completes, pair discarded
    f0 = m_frames;
    n0 = s_cyc.size();
    @(posedge iCLK); #1;
    iPENIRQ_n = 1'b0;
    wait_cs(1'b0, 100, "t3_cs_fall");
    idle(1500);
    iPENIRQ_n = 1'b1;
    wait_cs(1'b1, FRAME_CYC, "t3_cs_rise");
    check("t3_rises", 32'(m_last_rises), 32'd48);
    idle(1500);
    check("t3_no_strobe", 32'(s_cyc.size() - n0), 32'd0);
    check("t3_x_held", 32'(oX_COORD), 32'(px));
    check("t3_y_held", 32'(oY_COORD), 32'(py));
    check("t3_frames", 32'(m_frames - f0), 32'd1);
    check("t3_idle_cs", 32'(oADC_CS_n), 32'd1);

    // Bit alignment with ignored slots driven high
    fill_ones = 1'b1;
    vals[0] = 12'h800;
    vals[1] = 12'h001;
    for (int j = 0; j < 2; j++) begin
      f0 = m_frames;
      xs[f0] = vals[j];
      n0 = s_cyc.size();
      @(posedge iCLK); #1;
      iPENIRQ_n = 1'b0;
      wait_strobes(n0 + 1, LATENCY + 200, "t4_strobe_timeout");
      iPENIRQ_n = 1'b1;
      if (s_cyc.size() > n0) begin
        check("t4_x", 32'(s_x[n0]), 32'(vals[j]));
        check("t4_y", 32'(s_y[n0]), 32'(ys[f0]));
      end
      idle(1200);
    end
    fill_ones = 1'b0;

    // One-cycle pen glitch
    f0 = m_frames;
    n0 = s_cyc.size();
    irq0 = irq_hi;
    @(posedge iCLK); #1;
    iPENIRQ_n = 1'b0;
    @(posedge iCLK); #1;
    iPENIRQ_n = 1'b1;
    idle(FRAME_CYC + GAP + 200);
    check("t5_irq_cycles", 32'(irq_hi - irq0), 32'd1);
    check("t5_frames", 32'(m_frames - f0), 32'd1);
    check("t5_rises", 32'(m_last_rises), 32'd48);
    check("t5_no_strobe", 32'(s_cyc.size() - n0), 32'd0);
    check("t5_idle_cs", 32'(oADC_CS_n), 32'd1);

    // Reset at bit 30, then a fresh frame with the pen still down
    f0 = m_frames;
    xs[f0 + 1] = xs[f0];
    ys[f0 + 1] = ys[f0];
    n0 = s_cyc.size();
    @(posedge iCLK); #1;
    iPENIRQ_n = 1'b0;
    i = 0;
    while (!(m_falls == 30 && !oADC_CS_n) && i < FRAME_CYC) begin
      @(posedge iCLK);
      i++;
    end
    check("t6_reach_bit30", 32'(m_falls), 32'd30);
    #3;
    iRST_n = 1'b0;
    #1;
    check("t6_rst_cs_n", 32'(oADC_CS_n), 32'd1);
    check("t6_rst_dclk", 32'(oADC_DCLK), 32'd0);
    check("t6_rst_x",    32'(oX_COORD),  32'd0);
    check("t6_rst_y",    32'(oY_COORD),  32'd0);
    check("t6_rst_irq",  32'(oTOUCH_IRQ), 32'd0);
    idle(3);
    iRST_n = 1'b1;
    t0 = cyc;
    wait_strobes(n0 + 1, LATENCY + 200, "t6_strobe_timeout");
    iPENIRQ_n = 1'b1;
    if (s_cyc.size() > n0) begin
      check("t6_latency", 32'(s_cyc[n0] - t0), 32'(LATENCY));
      check("t6_x", 32'(s_x[n0]), 32'(xs[f0 + 1]));
      check("t6_y", 32'(s_y[n0]), 32'(ys[f0 + 1]));
    end
    check("t6_cmd_x", 32'(m_cmd_x), 32'h92);
    check("t6_cmd_y", 32'(m_cmd_y), 32'hD2);
    check("t6_rises", 32'(m_last_rises), 32'd48);
    idle(1200);
    check("t6_strobe_count", 32'(s_cyc.size() - n0), 32'd1);

    check("no_back_to_back", 32'(back2back), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/touch_adc_sequencer.md
# touch_adc_sequencer

Sequences the resistive touch-panel ADC (ADS7843-class, 24-clock serial frame) that supplies the coordinates consumed by the touch IRQ/display logic. On pen-down it runs back-to-back X and Y conversions over a 4-wire serial bus, publishes a 12-bit coordinate pair with a one-cycle strobe, and repeats at a fixed sample interval while the pen stays down. It sits between the LCD-board ADC pins and the coordinate consumers (`iX_COORD`/`iY_COORD`/`iNEW_COORD` side).

## Interface

Reset is `iRST_n` (asynchronous, active-low). The clock is `iCLK`.

Parameters:
- `CLK_DIV`, default 25: `iCLK` cycles per DCLK half period, giving DCLK = `iCLK`/(2·`CLK_DIV`), 1 MHz at 50 MHz.
- `SAMPLE_GAP`, default 24'd500000: idle `iCLK` cycles between conversion pairs (10 ms).
- `CMD_X`, default 8'h92: control byte for an X conversion.
- `CMD_Y`, default 8'hD2: control byte for a Y conversion.

Ports:
- `iCLK`, in, 1: system clock, 50 MHz.
- `iRST_n`, in, 1: asynchronous active-low reset.
- `iPENIRQ_n`, in, 1: ADC pen interrupt, active low, asynchronous.
- `iADC_DOUT`, in, 1: ADC serial data out.
- `oADC_DCLK`, out, 1: serial clock; idles low.
- `oADC_DIN`, out, 1: serial command data.
- `oADC_CS_n`, out, 1: ADC chip select, active low.
- `oX_COORD`, out, 12: last published X.
- `oY_COORD`, out, 12: last published Y.
- `oNEW_COORD`, out, 1: one-cycle strobe when a new pair is published.
- `oTOUCH_IRQ`, out, 1: synchronized pen-down level, active high.

## Operation

- **Pen-down sync:** `iPENIRQ_n` passes through a 2-flop synchronizer. `oTOUCH_IRQ` = NOT synchronized value.
- **FSM states:** IDLE, CONV, PUBLISH, GAP.
  - **IDLE:** CS_n=1, DCLK=0, DIN=0. If `oTOUCH_IRQ`=1, go to CONV.
  - **CONV:** CS_n=0 for one continuous 48-DCLK frame.
    - X sub-frame: bits 0–23.
    - Y sub-frame: bits 24–47.
    - Bit counter runs 0..47. Per sub-frame, bit k = counter mod 24.
    - DIN carries command bit 7−k for k=0..7, and 0 otherwise.
    - DOUT is sampled for k=9..20 into result bits 11..0, MSB first. All other samples are ignored.
    - After bit 47 completes, go to PUBLISH.
  - **PUBLISH:** one cycle with CS_n=1.
    - If `oTOUCH_IRQ`=1: load `oX_COORD`/`oY_COORD` from the shadow registers and pulse `oNEW_COORD`=1.
    - Else: discard the pair (outputs held, no strobe).
    - In either case, go to GAP.
  - **GAP:** count `SAMPLE_GAP` cycles. At terminal count, go to CONV if `oTOUCH_IRQ`=1, else IDLE.
- **Pen release mid-CONV:** the frame is completed, never truncated; the pair is then discarded in PUBLISH.
- **Shadow registers:** the X and Y shadows are separate. Outputs change only in PUBLISH, so `oX_COORD`/`oY_COORD` are never a mixed-frame pair.
- **Reset values:**
  - Outputs: CS_n=1, DCLK=0, DIN=0, coords 12'h000, `oNEW_COORD`=0, `oTOUCH_IRQ`=0.
  - Internals: FSM=IDLE, all counters 0.
- **Reset mid-frame:** asynchronous, returns to reset state immediately. No partial publish.

## Timing

- **DCLK bit structure:** each bit is `CLK_DIV` cycles with DCLK low, then `CLK_DIV` cycles with DCLK high.
  - DIN updates on the first cycle of the low half.
  - DOUT is registered on the first cycle of the high half.
- **CS_n setup:** CS_n falls on the first cycle of bit 0's low half, at least `CLK_DIV` cycles before the first rising DCLK.
- **Frame length:** 48·2·`CLK_DIV` = 2400 cycles at default.
- **Latency:** from `iPENIRQ_n` falling to `oNEW_COORD` is 2 (sync) + 1 (IDLE→CONV) + 2400 + 1 = 2404 cycles at default.
- **Repeat period while held:** 2400 + 1 + `SAMPLE_GAP` + 1 cycles.
- **Counter widths:**
  - Divider: clog2(`CLK_DIV`).
  - Bit counter: 6 bits.
  - Gap counter: 24 bits, wrap-free (it is cleared on entry to GAP).
- **Strobe:** `oNEW_COORD` is high exactly one cycle per published pair; it is never asserted back-to-back.

## Structure

- **Shared package `touch_pkg`:**
  - `COORD_W`=12.
  - Default `CMD_X`/`CMD_Y` constants.
  - FSM state enum.
  - Sub-frame constants: `FRAME_BITS`=24, `DATA_FIRST`=9, `DATA_LAST`=20.
- **Sub-module `touch_spi_frame`:**
  - Generates DCLK, DIN and bit index from divider/bit counters and exposes a sample strobe.
  - The top-level FSM owns CS_n, the gap counter, the shadows and publishing.

## Test plan

- **Single touch:** ADC model returns X=12'hABC, Y=12'h123, command bytes checked as 8'h92 then 8'hD2. Pull `iPENIRQ_n` low, hold for 3000 cycles, release. Required: exactly one `oNEW_COORD` at cycle 2404, with `oX_COORD`=12'hABC and `oY_COORD`=12'h123.
- **Held pen:** `SAMPLE_GAP`=1000, model alternates X between 12'h001 and 12'hFFF. Required: strobes spaced 3402 cycles apart, with values alternating.
- **Release mid-frame:** release at cycle 1500 of CONV. Required: CONV runs the full 48 bits, no strobe, coords keep their prior values, FSM returns to IDLE after GAP.
- **Reset mid-frame:** assert `iRST_n`=0 at bit 30. Required: same cycle CS_n=1, DCLK=0, coords 0; after release with the pen down, a fresh frame starts at bit 0.
- **Bit alignment:** model drives X=12'h800 (MSB only), then X=12'h001 (LSB only). Required: captured X equals 12'h800 and 12'h001 respectively, and DOUT on k=8 and k=21 is ignored (driven 1, no effect).
- **Glitch:** a 1-cycle `iPENIRQ_n` low pulse. Required: `oTOUCH_IRQ` is high at most 1 cycle and, if seen by IDLE, one full frame followed by discard (no strobe).
